// File: rtl/kb_pkg.sv
// Shared keycode constants, FSM state type and the raw-code cleanup helper
// used by the keyboard event generator.
package kb_pkg;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_Z     = 8'h1D;
  localparam logic [7:0] KC_BKSP  = 8'h2A;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_REPEAT
  } kb_state_t;

  // USB HID reports 0x01..0x03 for rollover/POST errors; they mean "no usable key".
  function automatic logic [7:0] sanitize_code(input logic [7:0] code);
    return ((code >= 8'h01) && (code <= 8'h03)) ? KC_NONE : code;
  endfunction

endpackage

// File: rtl/keycode_classify.sv
// Combinational decode of a keycode into the categories the crossword logic
// cares about, plus whether the key auto-repeats.
module keycode_classify
  import kb_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_arrow,
  output logic       is_letter,
  output logic       is_backspace,
  output logic [4:0] letter_idx,
  output logic       repeatable
);

  always_comb begin
    is_arrow     = (code == KC_RIGHT) || (code == KC_LEFT) ||
                   (code == KC_DOWN)  || (code == KC_UP);
    is_letter    = (code >= KC_A) && (code <= KC_Z);
    is_backspace = (code == KC_BKSP);
    // Letters sit below 0x20, so the low five bits carry the whole offset.
    letter_idx   = is_letter ? (code[4:0] - 5'd4) : 5'd0;
    repeatable   = is_arrow || is_backspace;
  end

endmodule

// File: rtl/keycode_event_gen.sv
// Turns the level-held USB keycode into debounced single-cycle key events with
// typematic repeat for arrows and backspace.
module keycode_event_gen
  import kb_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_RATE   = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  input  logic       tick,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       is_repeat,
  output logic       is_arrow,
  output logic       is_letter,
  output logic       is_backspace,
  output logic [4:0] letter_idx
);

  localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam int TCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TCNT_W   = $clog2(TCNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(STABLE_CYCLES);
  localparam logic [TCNT_W-1:0] DELAY_LAST = TCNT_W'(REPEAT_DELAY - 1);
  localparam logic [TCNT_W-1:0] DELAY_SAT  = TCNT_W'(REPEAT_DELAY);
  localparam logic [TCNT_W-1:0] RATE_LAST  = TCNT_W'(REPEAT_RATE - 1);

  logic [7:0]        sync1_q, sync1_d;
  logic [7:0]        sync2_q, sync2_d;
  kb_state_t         state_q, state_d;
  logic [7:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              key_event_q, key_event_d;
  logic              is_repeat_q, is_repeat_d;
  logic [7:0]        key_code_q, key_code_d;

  logic [7:0] sk;
  logic       emit_first;
  logic       emit_repeat;
  logic       cand_repeatable;

  logic       cand_arrow_unused;
  logic       cand_letter_unused;
  logic       cand_bksp_unused;
  logic [4:0] cand_idx_unused;
  logic       code_repeatable_unused;

  always_comb begin
    sync1_d = keycode_in;
    sync2_d = sync1_q;
  end

  assign sk = sanitize_code(sync2_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      key_event_q <= 1'b0;
      is_repeat_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      key_event_q <= key_event_d;
      is_repeat_q <= is_repeat_d;
      key_code_q  <= key_code_d;
    end
  end

  // A release or code change outranks everything, including a coincident tick.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    emit_first  = 1'b0;
    emit_repeat = 1'b0;
    if (state_q == ST_IDLE) begin
      if (sk != KC_NONE) begin
        cand_d  = sk;
        cnt_d   = CNT_W'(1);
        state_d = ST_DEBOUNCE;
      end
    end else if (sk == KC_NONE) begin
      state_d = ST_IDLE;
    end else if (sk != cand_q) begin
      cand_d  = sk;
      cnt_d   = CNT_W'(1);
      state_d = ST_DEBOUNCE;
    end else begin
      case (state_q)
        ST_DEBOUNCE: begin
          if (cnt_q == CNT_DONE) begin
            emit_first = 1'b1;
            tcnt_d     = '0;
            state_d    = ST_HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (tick) begin
            if (cand_repeatable && (tcnt_q == DELAY_LAST)) begin
              emit_repeat = 1'b1;
              tcnt_d      = '0;
              state_d     = ST_REPEAT;
            end else if (tcnt_q != DELAY_SAT) begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (tick) begin
            if (tcnt_q == RATE_LAST) begin
              emit_repeat = 1'b1;
              tcnt_d      = '0;
            end else begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    key_event_d = emit_first | emit_repeat;
    is_repeat_d = emit_repeat;
    key_code_d  = (emit_first | emit_repeat) ? cand_q : key_code_q;
  end

  keycode_classify u_cls_cand (
    .code         (cand_q),
    .is_arrow     (cand_arrow_unused),
    .is_letter    (cand_letter_unused),
    .is_backspace (cand_bksp_unused),
    .letter_idx   (cand_idx_unused),
    .repeatable   (cand_repeatable)
  );

  keycode_classify u_cls_out (
    .code         (key_code_q),
    .is_arrow     (is_arrow),
    .is_letter    (is_letter),
    .is_backspace (is_backspace),
    .letter_idx   (letter_idx),
    .repeatable   (code_repeatable_unused)
  );

  assign key_event = key_event_q;
  assign key_code  = key_code_q;
  assign is_repeat = is_repeat_q;

endmodule
